// File: rtl/cp0_tlb_regs.sv
// rtl/cp0_tlb_regs.sv - CP0 register bank: Index/Random/EntryLo/EntryHi/Context/Status/Cause/EPC.
// Answers mtc0/mfc0, exception/eret updates and drives the TLB write port.
module cp0_tlb_regs #(
  parameter int TLB_ENTRIES = 8,
  parameter int IDX_W       = 3
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [31:0]      wd,
  input  logic             windex,
  input  logic             wentlo,
  input  logic             wcontx,
  input  logic             wenthi,
  input  logic             wepc,
  input  logic             wcau,
  input  logic             wsta,
  input  logic             exce,
  input  logic             eret,
  input  logic             itlb_exce,
  input  logic             dtlb_exce,
  input  logic [1:0]       sepc,
  input  logic [31:0]      vpc,
  input  logic [31:0]      pcd,
  input  logic [31:0]      pcm,
  input  logic [31:0]      pcw,
  input  logic [31:0]      i_vaddr,
  input  logic [31:0]      d_vaddr,
  input  logic [31:0]      cause_in,
  input  logic [1:0]       c0rn,
  input  logic             tlbwr,
  output logic [31:0]      sta,
  output logic [31:0]      epc,
  output logic [31:0]      c0_rdata,
  output logic [IDX_W-1:0] tlb_widx,
  output logic [19:0]      tlb_wvpn,
  output logic [31:0]      tlb_wpte
);

  localparam logic [IDX_W-1:0] RANDOM_TOP = IDX_W'(TLB_ENTRIES - 1);

  logic [IDX_W-1:0] index_q, index_d;
  logic [IDX_W-1:0] random_q, random_d;
  logic [31:0]      entrylo_q, entrylo_d;
  logic [19:0]      vpn_q, vpn_d;
  logic [9:0]       ptebase_q, ptebase_d;
  logic [19:0]      badvpn_q, badvpn_d;
  logic [31:0]      sta_q, sta_d;
  logic [31:0]      cause_q, cause_d;
  logic [31:0]      epc_q, epc_d;
  logic [31:0]      epc_src;
  logic [31:0]      context_w;

  always_comb begin
    epc_src = vpc;
    case (sepc)
      2'b00: epc_src = vpc;
      2'b01: epc_src = pcd;
      2'b10: epc_src = pcm;
      2'b11: epc_src = pcw;
      default: epc_src = vpc;
    endcase
  end

  always_comb begin
    index_d   = index_q;
    random_d  = (random_q == '0) ? RANDOM_TOP : random_q - IDX_W'(1);
    entrylo_d = entrylo_q;
    vpn_d     = vpn_q;
    ptebase_d = ptebase_q;
    badvpn_d  = badvpn_q;
    sta_d     = sta_q;
    cause_d   = cause_q;
    epc_d     = epc_q;

    if (windex) index_d = wd[IDX_W-1:0];
    if (wentlo) entrylo_d = wd;

    // Instruction-side TLB faults take precedence over data-side ones.
    if (itlb_exce)      vpn_d = i_vaddr[31:12];
    else if (dtlb_exce) vpn_d = d_vaddr[31:12];
    else if (wenthi)    vpn_d = wd[31:12];

    if (wcontx) ptebase_d = wd[31:22];
    if (itlb_exce)      badvpn_d = i_vaddr[31:12];
    else if (dtlb_exce) badvpn_d = d_vaddr[31:12];

    // Status holds a 4-bit-per-level mode stack: push on exception, pop on eret.
    if (wsta) begin
      if (exce)      sta_d = sta_q << 4;
      else if (eret) sta_d = sta_q >> 4;
      else           sta_d = wd;
    end

    if (wcau) cause_d = exce ? cause_in : wd;
    if (wepc) epc_d = exce ? epc_src : wd;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      index_q   <= '0;
      random_q  <= RANDOM_TOP;
      entrylo_q <= '0;
      vpn_q     <= '0;
      ptebase_q <= '0;
      badvpn_q  <= '0;
      sta_q     <= '0;
      cause_q   <= '0;
      epc_q     <= '0;
    end else begin
      index_q   <= index_d;
      random_q  <= random_d;
      entrylo_q <= entrylo_d;
      vpn_q     <= vpn_d;
      ptebase_q <= ptebase_d;
      badvpn_q  <= badvpn_d;
      sta_q     <= sta_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
    end
  end

  assign context_w = {ptebase_q, badvpn_q, 2'b00};

  always_comb begin
    c0_rdata = context_w;
    case (c0rn)
      2'b00: c0_rdata = context_w;
      2'b01: c0_rdata = sta_q;
      2'b10: c0_rdata = cause_q;
      2'b11: c0_rdata = epc_q;
      default: c0_rdata = context_w;
    endcase
  end

  assign sta      = sta_q;
  assign epc      = epc_q;
  assign tlb_widx = tlbwr ? random_q : index_q;
  assign tlb_wvpn = vpn_q;
  assign tlb_wpte = entrylo_q;

endmodule

// File: tb/tb_cp0_tlb_regs.sv
// tb/tb_cp0_tlb_regs.sv - self-checking bench for cp0_tlb_regs with a behavioural register model.
module tb_cp0_tlb_regs;
  localparam int N = 8;
  localparam int W = 3;

  logic clk, clrn;
  logic [31:0] wd, vpc, pcd, pcm, pcw, i_vaddr, d_vaddr, cause_in;
  logic windex, wentlo, wcontx, wenthi, wepc, wcau, wsta;
  logic exce, eret, itlb_exce, dtlb_exce, tlbwr;
  logic [1:0] sepc, c0rn;
  logic [31:0] sta, epc, c0_rdata, tlb_wpte;
  logic [W-1:0] tlb_widx;
  logic [19:0] tlb_wvpn;

  int total, bad;

  // Model state
  int          m_edges;
  int unsigned m_index, m_entrylo, m_vpn, m_ptebase, m_badvpn, m_sta, m_cause, m_epc;

  cp0_tlb_regs #(.TLB_ENTRIES(N), .IDX_W(W)) dut (
    .clk(clk), .clrn(clrn), .wd(wd), .windex(windex), .wentlo(wentlo), .wcontx(wcontx),
    .wenthi(wenthi), .wepc(wepc), .wcau(wcau), .wsta(wsta), .exce(exce), .eret(eret),
    .itlb_exce(itlb_exce), .dtlb_exce(dtlb_exce), .sepc(sepc), .vpc(vpc), .pcd(pcd),
    .pcm(pcm), .pcw(pcw), .i_vaddr(i_vaddr), .d_vaddr(d_vaddr), .cause_in(cause_in),
    .c0rn(c0rn), .tlbwr(tlbwr), .sta(sta), .epc(epc), .c0_rdata(c0_rdata),
    .tlb_widx(tlb_widx), .tlb_wvpn(tlb_wvpn), .tlb_wpte(tlb_wpte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned exp_random();
    return (N - 1) - (m_edges % N);
  endfunction

  function automatic int unsigned exp_context();
    return (m_ptebase << 22) | (m_badvpn << 2);
  endfunction

  function automatic int unsigned exp_read(input logic [1:0] sel);
    case (sel)
      2'd0: return exp_context();
      2'd1: return m_sta;
      2'd2: return m_cause;
      default: return m_epc;
    endcase
  endfunction

  task automatic model_reset();
    m_edges = 0; m_index = 0; m_entrylo = 0; m_vpn = 0; m_ptebase = 0;
    m_badvpn = 0; m_sta = 0; m_cause = 0; m_epc = 0;
  endtask

  task automatic model_edge();
    int unsigned src;
    if (!clrn) return;
    m_edges++;
    if (windex) m_index = wd % N;
    if (wentlo) m_entrylo = wd;
    if (itlb_exce)      m_vpn = i_vaddr >> 12;
    else if (dtlb_exce) m_vpn = d_vaddr >> 12;
    else if (wenthi)    m_vpn = wd >> 12;
    if (wcontx) m_ptebase = wd >> 22;
    if (itlb_exce)      m_badvpn = i_vaddr >> 12;
    else if (dtlb_exce) m_badvpn = d_vaddr >> 12;
    if (wsta) begin
      if (exce)      m_sta = m_sta * 16;
      else if (eret) m_sta = m_sta / 16;
      else           m_sta = wd;
    end
    if (wcau) m_cause = exce ? cause_in : wd;
    src = (sepc == 0) ? vpc : (sepc == 1) ? pcd : (sepc == 2) ? pcm : pcw;
    if (wepc) m_epc = exce ? src : wd;
  endtask

  task automatic clear_inputs();
    wd = 0; windex = 0; wentlo = 0; wcontx = 0; wenthi = 0; wepc = 0; wcau = 0; wsta = 0;
    exce = 0; eret = 0; itlb_exce = 0; dtlb_exce = 0; tlbwr = 0; sepc = 0; c0rn = 0;
    vpc = 0; pcd = 0; pcm = 0; pcw = 0; i_vaddr = 0; d_vaddr = 0; cause_in = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    clrn = 1'b1;
    #3 clrn = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    total++; if (sta !== 32'h0) begin bad++; $display("FAIL reset_sta got=%h exp=0", sta); end
    total++; if (epc !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h exp=0", epc); end
    total++; if (c0_rdata !== 32'h0) begin bad++; $display("FAIL reset_context got=%h exp=0", c0_rdata); end
    total++; if (tlb_widx !== 3'd0) begin bad++; $display("FAIL reset_widx got=%0d exp=0", tlb_widx); end
    total++; if (tlb_wvpn !== 20'h0 || tlb_wpte !== 32'h0) begin
      bad++; $display("FAIL reset_tlbw got=%h/%h exp=0/0", tlb_wvpn, tlb_wpte);
    end
    tlbwr = 1'b1; #1;
    total++; if (tlb_widx !== 3'd7) begin bad++; $display("FAIL reset_random got=%0d exp=7", tlb_widx); end
    clrn = 1'b1;
    model_reset();
    c0rn = 2'b01;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++; if (tlb_widx !== W'(exp_random())) begin
        bad++; $display("FAIL idle_random[%0d] got=%0d exp=%0d", i, tlb_widx, exp_random());
      end
      total++; if (sta !== 32'h0 || c0_rdata !== 32'h0) begin
        bad++; $display("FAIL idle_sta[%0d] got=%h/%h exp=0", i, sta, c0_rdata);
      end
      tick();
    end
    tlbwr = 1'b0;
  endtask

  task automatic test_mtc0();
    clear_inputs();
    wsta = 1; wd = 32'h30; tick(); clear_inputs(); #1;
    total++; if (sta !== 32'h30 || sta !== m_sta) begin bad++; $display("FAIL mtc0_sta got=%h exp=30", sta); end
    windex = 1; wd = 32'h5; tick(); clear_inputs(); #1;
    total++; if (tlb_widx !== 3'd5) begin bad++; $display("FAIL mtc0_index got=%0d exp=5", tlb_widx); end
    wcontx = 1; wd = 32'hFFC0_0ABC; tick();
    wcontx = 0; wentlo = 1; wd = 32'h1234_5A5F; tick();
    wentlo = 0; wenthi = 1; wd = 32'hCAFE_B123; tick(); clear_inputs(); #1;
    total++; if (c0_rdata !== 32'hFFC0_0000) begin bad++; $display("FAIL mtc0_context got=%h exp=ffc00000", c0_rdata); end
    total++; if (tlb_wpte !== 32'h1234_5A5F) begin bad++; $display("FAIL mtc0_entrylo got=%h exp=12345a5f", tlb_wpte); end
    total++; if (tlb_wvpn !== 20'hCAFEB) begin bad++; $display("FAIL mtc0_entryhi got=%h exp=cafeb", tlb_wvpn); end
    for (int i = 0; i < 2 * N && exp_random() != 2; i++) tick();
    tlbwr = 1; #1;
    total++; if (exp_random() != 2 || tlb_widx !== 3'd2) begin
      bad++; $display("FAIL tlbwr_random got=%0d exp=2 (model %0d)", tlb_widx, exp_random());
    end
    tlbwr = 0;
  endtask

  task automatic test_dtlb();
    clear_inputs();
    d_vaddr = 32'h1234_5678; sepc = 2'b10; pcm = 32'h0040_0010; cause_in = 32'h14;
    exce = 1; dtlb_exce = 1; wsta = 1; wcau = 1; wepc = 1; wd = 32'hDEAD_BEEF;
    tick(); clear_inputs(); #1;
    total++; if (sta !== 32'h300) begin bad++; $display("FAIL dtlb_sta got=%h exp=300", sta); end
    total++; if (epc !== 32'h0040_0010) begin bad++; $display("FAIL dtlb_epc got=%h exp=00400010", epc); end
    total++; if (tlb_wvpn !== 20'h12345) begin bad++; $display("FAIL dtlb_vpn got=%h exp=12345", tlb_wvpn); end
    c0rn = 2'b10; #1;
    total++; if (c0_rdata !== 32'h14) begin bad++; $display("FAIL dtlb_cause got=%h exp=14", c0_rdata); end
    c0rn = 2'b00; #1;
    total++; if (c0_rdata !== 32'hFFC4_8D14) begin bad++; $display("FAIL dtlb_context got=%h exp=ffc48d14", c0_rdata); end
  endtask

  task automatic test_itlb();
    clear_inputs();
    i_vaddr = 32'hAAAA_A000; d_vaddr = 32'h5555_5000; sepc = 2'b01; pcd = 32'h80;
    exce = 1; itlb_exce = 1; dtlb_exce = 1; wepc = 1; wenthi = 1; wd = 32'h1111_1111;
    tick(); clear_inputs(); #1;
    total++; if (tlb_wvpn !== 20'hAAAAA) begin bad++; $display("FAIL itlb_vpn got=%h exp=aaaaa", tlb_wvpn); end
    total++; if (epc !== 32'h80) begin bad++; $display("FAIL itlb_epc got=%h exp=80", epc); end
    #1;
    total++; if (c0_rdata !== {10'h3FF, 20'hAAAAA, 2'b00}) begin
      bad++; $display("FAIL itlb_context got=%h exp=%h", c0_rdata, {10'h3FF, 20'hAAAAA, 2'b00});
    end
  endtask

  task automatic test_eret();
    clear_inputs();
    eret = 1; wsta = 1; wd = 32'hFFFF_FFFF; tick(); clear_inputs(); #1;
    total++; if (sta !== 32'h30) begin bad++; $display("FAIL eret_sta got=%h exp=30", sta); end
    exce = 1; eret = 1; wsta = 1; tick(); clear_inputs(); #1;
    total++; if (sta !== 32'h300) begin bad++; $display("FAIL exce_eret_sta got=%h exp=300", sta); end
  endtask

  task automatic test_random();
    logic [1:0] sel;
    for (int i = 0; i < 400; i++) begin
      wd = $urandom; vpc = $urandom; pcd = $urandom; pcm = $urandom; pcw = $urandom;
      i_vaddr = $urandom; d_vaddr = $urandom; cause_in = $urandom; sepc = 2'($urandom);
      windex = ($urandom_range(0, 3) == 0); wentlo = ($urandom_range(0, 3) == 0);
      wcontx = ($urandom_range(0, 3) == 0); wenthi = ($urandom_range(0, 3) == 0);
      wepc = ($urandom_range(0, 3) == 0); wcau = ($urandom_range(0, 3) == 0);
      wsta = ($urandom_range(0, 2) == 0); exce = ($urandom_range(0, 4) == 0);
      eret = ($urandom_range(0, 4) == 0); itlb_exce = ($urandom_range(0, 6) == 0);
      dtlb_exce = ($urandom_range(0, 6) == 0); tlbwr = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 4; k++) begin
        sel = 2'(k); c0rn = sel; #1;
        total++; if (c0_rdata !== exp_read(sel)) begin
          bad++; $display("FAIL rand_rdata[%0d] c0rn=%0d got=%h exp=%h", i, k, c0_rdata, exp_read(sel));
        end
      end
      total++; if (sta !== m_sta || epc !== m_epc) begin
        bad++; $display("FAIL rand_sta_epc[%0d] got=%h/%h exp=%h/%h", i, sta, epc, m_sta, m_epc);
      end
      total++; if (tlb_wvpn !== 20'(m_vpn) || tlb_wpte !== m_entrylo) begin
        bad++; $display("FAIL rand_tlbw[%0d] got=%h/%h exp=%h/%h", i, tlb_wvpn, tlb_wpte, m_vpn, m_entrylo);
      end
      total++; if (tlb_widx !== W'(tlbwr ? exp_random() : m_index)) begin
        bad++; $display("FAIL rand_widx[%0d] got=%0d exp=%0d", i, tlb_widx, tlbwr ? exp_random() : m_index);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    clear_inputs();
    wepc = 1; wd = 32'h80; tick();
    wepc = 0; wsta = 1; wcau = 1; windex = 1; wd = 32'h6; tick(); clear_inputs();
    #1;
    total++; if (epc !== 32'h80 || sta !== 32'h6) begin bad++; $display("FAIL pre_reset got=%h/%h exp=80/6", epc, sta); end
    #1 clrn = 1'b0;
    #1;
    model_reset();
    total++; if (epc !== 32'h0 || sta !== 32'h0) begin bad++; $display("FAIL async_epc_sta got=%h/%h exp=0/0", epc, sta); end
    total++; if (tlb_widx !== 3'd0) begin bad++; $display("FAIL async_index got=%0d exp=0", tlb_widx); end
    c0rn = 2'b10; #1;
    total++; if (c0_rdata !== 32'h0) begin bad++; $display("FAIL async_cause got=%h exp=0", c0_rdata); end
    tlbwr = 1; #1;
    total++; if (tlb_widx !== 3'd7) begin bad++; $display("FAIL async_random got=%0d exp=7", tlb_widx); end
    @(posedge clk); #1;
    clrn = 1'b1;
    tick();
    total++; if (tlb_widx !== 3'd6 || tlb_widx !== W'(exp_random())) begin
      bad++; $display("FAIL post_reset_random got=%0d exp=6", tlb_widx);
    end
    tlbwr = 0;
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_mtc0();
    test_dtlb();
    test_itlb();
    test_eret();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
